// File: rtl/axil_reg_slave.sv
// AXI-Lite register-bank responder with bounded, programmable READY wait states.
// All outputs come straight from flops; read and write paths run independently.
module axil_reg_slave #(
   parameter int unsigned C_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_AXI_ADDR_WIDTH = 8,
   parameter int unsigned NUM_REGS         = 16,
   parameter int unsigned WAIT_CYCLES      = 1
) (
   input  logic                          AXI_ACLK,
   input  logic                          AXI_ARESET,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
   input  logic                          AXI_ARVALID,
   output logic                          AXI_ARREADY,
   output logic [C_AXI_DATA_WIDTH-1:0]   AXI_RDATA,
   output logic                          AXI_RVALID,
   input  logic                          AXI_RREADY,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
   input  logic                          AXI_AWVALID,
   output logic                          AXI_AWREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
   input  logic                          AXI_WVALID,
   output logic                          AXI_WREADY,
   output logic [1:0]                    AXI_BRESP,
   output logic                          AXI_BVALID,
   input  logic                          AXI_BREADY
);

   localparam int unsigned CNT_W    = 3;
   localparam int unsigned NUM_CH   = 3;
   localparam int unsigned CH_AR    = 0;
   localparam int unsigned CH_AW    = 1;
   localparam int unsigned CH_W     = 2;
   localparam int unsigned REG_IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned ADDR_LIM = NUM_REGS * 4;

   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   r_state_t                       r_state;
   r_state_t                       w_state_nxt;
   logic [NUM_CH-1:0]              r_rdy;
   logic [NUM_CH-1:0]              w_valid;
   logic [NUM_CH-1:0]              w_idle;
   logic                           r_aw_held;
   logic                           r_w_held;
   logic [C_AXI_ADDR_WIDTH-1:0]    r_awaddr;
   logic [C_AXI_DATA_WIDTH-1:0]    r_wdata;
   logic                           r_bvalid;
   logic [1:0]                     r_bresp;
   logic                           r_rvalid;
   logic [C_AXI_DATA_WIDTH-1:0]    r_rdata;
   logic [C_AXI_DATA_WIDTH-1:0]    r_regs [NUM_REGS];

   logic                           w_ar_hs;
   logic                           w_aw_hs;
   logic                           w_w_hs;
   logic                           w_b_hs;
   logic                           w_commit;
   logic [C_AXI_ADDR_WIDTH-1:0]    w_waddr;
   logic [C_AXI_DATA_WIDTH-1:0]    w_wd;
   logic                           w_win;
   logic [REG_IW-1:0]              w_widx;
   logic                           w_rin;
   logic [REG_IW-1:0]              w_ridx;
   logic                           w_rd_load;
   logic                           w_rd_done;

   assign w_ar_hs = AXI_ARVALID & r_rdy[CH_AR];
   assign w_aw_hs = AXI_AWVALID & r_rdy[CH_AW];
   assign w_w_hs  = AXI_WVALID  & r_rdy[CH_W];
   assign w_b_hs  = r_bvalid & AXI_BREADY;

   assign w_valid = {AXI_WVALID, AXI_AWVALID, AXI_ARVALID};
   assign w_idle  = {~r_w_held & ~r_bvalid, ~r_aw_held & ~r_bvalid, r_state == R_IDLE};

   // Per-channel wait counter: READY pulses for one cycle once VALID has been seen WAIT_CYCLES+1 times.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ready
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge AXI_ACLK) begin
         if (AXI_ARESET) begin
            r_cnt    <= '0;
            r_rdy[g] <= 1'b0;
         end else if (r_rdy[g]) begin
            r_cnt    <= '0;
            r_rdy[g] <= 1'b0;
         end else if (w_valid[g] && w_idle[g]) begin
            if (r_cnt == CNT_W'(WAIT_CYCLES)) begin
               r_cnt    <= '0;
               r_rdy[g] <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   // A handshake in this cycle counts as held so the commit lands on the same edge.
   assign w_waddr  = w_aw_hs ? AXI_AWADDR : r_awaddr;
   assign w_wd     = w_w_hs  ? AXI_WDATA  : r_wdata;
   assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs) & ~r_bvalid;
   assign w_win    = 32'(w_waddr) < ADDR_LIM;
   assign w_widx   = w_waddr[REG_IW+1:2];

   always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESET) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         if (w_b_hs) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= AXI_AWADDR;
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= AXI_WDATA;
         end
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_win ? 2'b00 : 2'b10;
            if (w_win) r_regs[w_widx] <= w_wd;
         end
      end
   end

   assign w_rin  = 32'(AXI_ARADDR) < ADDR_LIM;
   assign w_ridx = AXI_ARADDR[REG_IW+1:2];

   always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESET) r_state <= R_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_load   = 1'b0;
      w_rd_done   = 1'b0;
      case (r_state)
         R_IDLE: if (w_ar_hs) begin
            w_state_nxt = R_DATA;
            w_rd_load   = 1'b1;
         end
         R_DATA: if (AXI_RREADY) begin
            w_state_nxt = R_IDLE;
            w_rd_done   = 1'b1;
         end
      endcase
   end

   // Read data sampled on the AR handshake edge, so a same-edge write is not visible.
   always_ff @(posedge AXI_ACLK) begin
      if (AXI_ARESET) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else if (w_rd_load) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rin ? r_regs[w_ridx] : '0;
      end else if (w_rd_done) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end
   end

   assign AXI_ARREADY = r_rdy[CH_AR];
   assign AXI_AWREADY = r_rdy[CH_AW];
   assign AXI_WREADY  = r_rdy[CH_W];
   assign AXI_BVALID  = r_bvalid;
   assign AXI_BRESP   = r_bresp;
   assign AXI_RVALID  = r_rvalid;
   assign AXI_RDATA   = r_rdata;

endmodule
